// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for DIV/DIVU, one quotient bit per clock.
// Returns {remainder, quotient} and holds it while the requester keeps start_i high.
module div_radix2 #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      DBZ,
      DIV,
      DONE
   } state_t;

   state_t             state_reg, state_next;
   logic [CW-1:0]      cnt_reg, cnt_next;
   logic [WIDTH:0]     rem_reg, rem_next;
   logic [WIDTH-1:0]   dvd_reg, dvd_next;
   logic [WIDTH-1:0]   div_reg, div_next;
   logic               neg_q_reg, neg_q_next;
   logic               neg_r_reg, neg_r_next;
   logic [2*WIDTH-1:0] result_reg, result_next;
   logic               ready_reg, ready_next;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     shifted, diff, rem_step;
   logic               fits;
   logic [WIDTH-1:0]   quo_step, quo_fix, rem_fix;

   // Operand magnitudes are only taken in signed mode.
   assign a_neg = signed_div_i & opdata1_i[WIDTH-1];
   assign b_neg = signed_div_i & opdata2_i[WIDTH-1];
   assign a_mag = a_neg ? -opdata1_i : opdata1_i;
   assign b_mag = b_neg ? -opdata2_i : opdata2_i;

   // Shift the next dividend bit into the partial remainder, then try the subtract.
   assign shifted  = (rem_reg << 1) | {{WIDTH{1'b0}}, dvd_reg[WIDTH-1]};
   assign diff     = shifted - {1'b0, div_reg};
   assign fits     = ~diff[WIDTH];
   assign rem_step = fits ? diff : shifted;
   assign quo_step = {dvd_reg[WIDTH-2:0], fits};
   assign quo_fix  = neg_q_reg ? -quo_step : quo_step;
   assign rem_fix  = neg_r_reg ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         rem_reg    <= '0;
         dvd_reg    <= '0;
         div_reg    <= '0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         result_reg <= '0;
         ready_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         rem_reg    <= rem_next;
         dvd_reg    <= dvd_next;
         div_reg    <= div_next;
         neg_q_reg  <= neg_q_next;
         neg_r_reg  <= neg_r_next;
         result_reg <= result_next;
         ready_reg  <= ready_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      rem_next    = rem_reg;
      dvd_next    = dvd_reg;
      div_next    = div_reg;
      neg_q_next  = neg_q_reg;
      neg_r_next  = neg_r_reg;
      result_next = result_reg;
      ready_next  = ready_reg;

      case (state_reg)
         IDLE: begin
            ready_next  = 1'b0;
            result_next = '0;
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_next = DBZ;
               end else begin
                  state_next = DIV;
                  dvd_next   = a_mag;
                  div_next   = b_mag;
                  rem_next   = '0;
                  cnt_next   = '0;
                  neg_q_next = a_neg ^ b_neg;
                  neg_r_next = a_neg;
               end
            end
         end
         DBZ: begin
            // Divide by zero yields zero; ready follows one cycle later from DONE.
            result_next = '0;
            ready_next  = 1'b0;
            state_next  = annul_i ? IDLE : DONE;
         end
         DIV: begin
            if (annul_i) begin
               state_next  = IDLE;
               ready_next  = 1'b0;
               result_next = '0;
            end else begin
               rem_next = rem_step;
               dvd_next = quo_step;
               cnt_next = cnt_reg + CW'(1);
               if (cnt_reg == CW'(WIDTH - 1)) begin
                  result_next = {rem_fix, quo_fix};
                  ready_next  = 1'b1;
                  state_next  = DONE;
               end
            end
         end
         DONE: begin
            if (!start_i || annul_i) begin
               state_next  = IDLE;
               ready_next  = 1'b0;
               result_next = '0;
            end else begin
               ready_next = 1'b1;
            end
         end
         default: begin
            state_next  = IDLE;
            ready_next  = 1'b0;
            result_next = '0;
         end
      endcase
   end

   assign result_o = result_reg;
   assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_radix2.sv
// Scoreboard bench for div_radix2: stimulus pushes expected results, a monitor
// pops and compares them whenever ready_o rises.
module tb_div_radix2;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           resetn = 1'b0;
   logic           signed_div = 1'b0;
   logic [W-1:0]   op1 = '0;
   logic [W-1:0]   op2 = '0;
   logic           start = 1'b0;
   logic           annul = 1'b0;
   logic [2*W-1:0] result;
   logic           ready;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [2*W-1:0] val;
      string          name;
   } exp_t;

   exp_t sb_q[$];

   div_radix2 #(.WIDTH(W)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   // Monitor: compare each new result against the oldest expectation.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (ready === 1'b1 && prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
               check_int("unexpected ready", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check_val({e.name, " result"}, result, e.val);
               $display("txn %s: result=%h expected=%h", e.name, result, e.val);
            end
         end
         prev = ready;
      end
   end

   task automatic run_op(input string name, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] exp_val,
                         input int exp_lat, input bit scramble);
      int cycles;
      exp_t e;
      @(negedge clk);
      signed_div = sgn;
      op1 = a;
      op2 = b;
      start = 1'b1;
      annul = 1'b0;
      e.val = exp_val;
      e.name = name;
      sb_q.push_back(e);
      @(posedge clk);
      cycles = 0;
      do begin
         @(posedge clk);
         cycles++;
         #1;
         if (scramble && cycles == 5) begin
            op1 = $urandom;
            op2 = $urandom;
            signed_div = ~sgn;
         end
      end while (ready !== 1'b1 && cycles < 100);
      check_int({name, " latency"}, cycles, exp_lat);
   endtask

   task automatic release_op(input string name);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check_int({name, " ready drop"}, int'(ready), 0);
      check_val({name, " result clear"}, result, '0);
   endtask

   task automatic hold_check(input string name, input logic [2*W-1:0] exp_val, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check_int({name, " hold ready"}, int'(ready), 1);
         check_val({name, " hold result"}, result, exp_val);
      end
   endtask

   task automatic annul_op(input string name, input int step);
      bit seen;
      @(negedge clk);
      signed_div = 1'b0;
      op1 = 32'd100;
      op2 = 32'd7;
      start = 1'b1;
      @(posedge clk);
      repeat (step - 1) @(posedge clk);
      #1;
      annul = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      annul = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ready === 1'b1) seen = 1'b1;
      end
      check_int({name, " no ready"}, int'(seen), 0);
      $display("txn %s: annulled at step %0d", name, step);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      n_bad++;
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      check_int("reset ready", int'(ready), 0);
      check_val("reset result", result, '0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      run_op("u100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 32, 1'b0);
      hold_check("u100/7", {32'd2, 32'd14}, 3);
      release_op("u100/7");

      run_op("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 32, 1'b0);
      release_op("s-7/2");
      run_op("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 32, 1'b0);
      release_op("s7/-2");
      run_op("smin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 32, 1'b0);
      release_op("smin/-1");
      run_op("s-100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 32, 1'b0);
      release_op("s-100/-7");
      run_op("uFFFFFFF9/2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 32, 1'b0);
      release_op("uFFFFFFF9/2");

      run_op("dbz", 1'b0, 32'd5, 32'd0, 64'd0, 2, 1'b0);
      release_op("dbz");

      annul_op("annul10", 10);
      run_op("u9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 32, 1'b0);
      release_op("u9/3");
      annul_op("annul32", 32);

      // Reset in the middle of an operation.
      @(negedge clk);
      signed_div = 1'b0;
      op1 = 32'd100;
      op2 = 32'd7;
      start = 1'b1;
      @(posedge clk);
      repeat (19) @(posedge clk);
      #1;
      resetn = 1'b0;
      start = 1'b0;
      #1;
      check_int("rst mid ready", int'(ready), 0);
      check_val("rst mid result", result, '0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_int("rst mid idle", int'(ready), 0);
      $display("txn rst_mid: reset at step 20");

      run_op("uFFFFFFFF/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 32, 1'b0);
      // Reset while a result is held: outputs must clear without a clock edge.
      @(negedge clk);
      #1;
      resetn = 1'b0;
      start = 1'b0;
      #1;
      check_int("rst done ready", int'(ready), 0);
      check_val("rst done result", result, '0);
      @(negedge clk);
      resetn = 1'b1;

      run_op("u1000/33", 1'b0, 32'd1000, 32'd33, {32'd10, 32'd30}, 32, 1'b0);
      release_op("u1000/33");
      run_op("u12345/100 scr", 1'b0, 32'd12345, 32'd100, {32'd45, 32'd123}, 32, 1'b1);
      release_op("u12345/100 scr");
      run_op("u5/9", 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 32, 1'b0);
      release_op("u5/9");

      repeat (3) @(negedge clk);
      check_int("scoreboard drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
